// File: rtl/priority_req_holder.sv
// Request-holding stage for the 8-bit priority circuit: sticky pending vector out,
// one-hot select back in, registered grant with a valid/ready handshake.
//
// state | meaning
// IDLE  | no grant offered; arbitrate from pend and sel_i
// OFFER | grant_valid high, grant held until grant_ready
module priority_req_holder #(
  parameter int WIDTH  = 8,
  parameter int IDX_W  = 3,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  req_i,
  output logic [WIDTH-1:0]  pend_o,
  input  logic [WIDTH-1:0]  sel_i,
  output logic              grant_valid,
  input  logic              grant_ready,
  output logic [WIDTH-1:0]  grant_onehot,
  output logic [IDX_W-1:0]  grant_idx,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              err_o
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t           state;
  logic             accept;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] pend_next;
  logic             drop_hit;
  logic             sel_onehot;
  logic             sel_subset;
  logic             sel_ok;

  function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = i[IDX_W-1:0];
    end
    return r;
  endfunction

  assign accept     = grant_valid & grant_ready;
  assign clr        = accept ? grant_onehot : '0;
  // A request landing on the bit being cleared re-sets it: new request wins.
  assign pend_next  = (pend_o & ~clr) | req_i;
  assign drop_hit   = |(req_i & pend_o & ~clr);
  assign sel_onehot = (sel_i != '0) && ((sel_i & (sel_i - WIDTH'(1))) == '0);
  assign sel_subset = (sel_i & pend_o) == sel_i;
  assign sel_ok     = sel_onehot & sel_subset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_o <= '0;
    end else begin
      pend_o <= pend_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_hit && (drop_cnt != {DROP_W{1'b1}})) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_valid  <= 1'b0;
      grant_onehot <= '0;
      grant_idx    <= '0;
      err_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_o != '0) begin
            if (sel_ok) begin
              grant_onehot <= sel_i;
              grant_idx    <= encode(sel_i);
              grant_valid  <= 1'b1;
              state        <= OFFER;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        OFFER: begin
          // Grant is frozen until accepted; later higher-priority requests wait.
          if (grant_ready) begin
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_req_holder.sv
// Directed bench for priority_req_holder; models the 8-bit priority circuit
// (highest set bit wins) on pend_o -> sel_i, with an override for bad selects.
module tb_priority_req_holder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_i;
  logic [7:0] pend_o;
  logic [7:0] sel_i;
  logic       grant_valid;
  logic       grant_ready;
  logic [7:0] grant_onehot;
  logic [2:0] grant_idx;
  logic [7:0] drop_cnt;
  logic       err_o;

  logic       force_en;
  logic [7:0] force_sel;

  int n_cmp = 0;
  int n_err = 0;

  priority_req_holder #(.WIDTH(8), .IDX_W(3), .DROP_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .pend_o       (pend_o),
    .sel_i        (sel_i),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .drop_cnt     (drop_cnt),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    sel_i = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (pend_o[i]) sel_i = 8'h01 << i;
    end
    if (force_en) sel_i = force_sel;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_i       = 8'h00;
    grant_ready = 1'b0;
    force_en    = 1'b0;
    force_sel   = 8'h00;
    #2;
    chk("rst_pend", 32'(pend_o), 32'h00);
    chk("rst_valid", 32'(grant_valid), 32'h0);
    chk("rst_onehot", 32'(grant_onehot), 32'h00);
    chk("rst_idx", 32'(grant_idx), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h00);
    chk("rst_err", 32'(err_o), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single request, accepted immediately
    req_i = 8'h04;
    tick();
    req_i = 8'h00;
    chk("t2_pend", 32'(pend_o), 32'h04);
    chk("t2_valid_early", 32'(grant_valid), 32'h0);
    grant_ready = 1'b1;
    tick();
    chk("t2_valid", 32'(grant_valid), 32'h1);
    chk("t2_onehot", 32'(grant_onehot), 32'h04);
    chk("t2_idx", 32'(grant_idx), 32'h2);
    tick();
    chk("t2_valid_after", 32'(grant_valid), 32'h0);
    chk("t2_pend_after", 32'(pend_o), 32'h00);
    grant_ready = 1'b0;

    // priority and hold
    req_i = 8'h11;
    tick();
    req_i = 8'h00;
    tick();
    chk("t3_onehot", 32'(grant_onehot), 32'h10);
    chk("t3_idx", 32'(grant_idx), 32'h4);
    tick();
    tick();
    tick();
    req_i = 8'h80;
    tick();
    req_i = 8'h00;
    chk("t3_pend", 32'(pend_o), 32'h91);
    chk("t3_hold_onehot", 32'(grant_onehot), 32'h10);
    tick();
    chk("t3_hold_valid", 32'(grant_valid), 32'h1);
    chk("t3_hold_onehot2", 32'(grant_onehot), 32'h10);
    grant_ready = 1'b1;
    tick();
    chk("t3_acc_valid", 32'(grant_valid), 32'h0);
    chk("t3_acc_pend", 32'(pend_o), 32'h81);
    tick();
    chk("t3_g2_onehot", 32'(grant_onehot), 32'h80);
    chk("t3_g2_idx", 32'(grant_idx), 32'h7);
    tick();
    chk("t3_g2_pend", 32'(pend_o), 32'h01);
    tick();
    chk("t3_g3_onehot", 32'(grant_onehot), 32'h01);
    chk("t3_g3_idx", 32'(grant_idx), 32'h0);
    tick();
    chk("t3_end_valid", 32'(grant_valid), 32'h0);
    chk("t3_end_pend", 32'(pend_o), 32'h00);

    // drain order, ready held high
    req_i = 8'hFF;
    tick();
    req_i = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      tick();
      chk("t4_valid", 32'(grant_valid), 32'h1);
      chk("t4_onehot", 32'(grant_onehot), 32'h1 << i);
      chk("t4_idx", 32'(grant_idx), 32'(i));
      tick();
      chk("t4_gap", 32'(grant_valid), 32'h0);
    end
    tick();
    chk("t4_idle_valid", 32'(grant_valid), 32'h0);
    chk("t4_idle_pend", 32'(pend_o), 32'h00);
    chk("t4_drop", 32'(drop_cnt), 32'h00);
    grant_ready = 1'b0;

    // drop counting and re-request on accept
    req_i = 8'h08;
    tick();
    chk("t5_drop0", 32'(drop_cnt), 32'h00);
    tick();
    chk("t5_drop1", 32'(drop_cnt), 32'h01);
    chk("t5_valid", 32'(grant_valid), 32'h1);
    grant_ready = 1'b1;
    tick();
    req_i = 8'h00;
    grant_ready = 1'b0;
    chk("t5_rereq_pend", 32'(pend_o), 32'h08);
    chk("t5_rereq_drop", 32'(drop_cnt), 32'h01);
    chk("t5_rereq_valid", 32'(grant_valid), 32'h0);
    req_i = 8'h08;
    for (int i = 0; i < 300; i++) tick();
    req_i = 8'h00;
    chk("t5_sat", 32'(drop_cnt), 32'hFF);
    tick();
    chk("t5_sat_hold", 32'(drop_cnt), 32'hFF);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    chk("t5_clear_pend", 32'(pend_o), 32'h00);

    // bad select: in-range one-hot but not pending
    req_i     = 8'h01;
    force_en  = 1'b1;
    force_sel = 8'h20;
    tick();
    req_i = 8'h00;
    chk("t6a_err_pre", 32'(err_o), 32'h0);
    tick();
    chk("t6a_err", 32'(err_o), 32'h1);
    chk("t6a_valid", 32'(grant_valid), 32'h0);
    tick();
    chk("t6a_valid2", 32'(grant_valid), 32'h0);

    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_err", 32'(err_o), 32'h0);
    chk("t6_rst_drop", 32'(drop_cnt), 32'h00);
    tick();
    rst_n = 1'b1;

    // bad select: not one-hot
    req_i     = 8'h01;
    force_sel = 8'h03;
    tick();
    req_i = 8'h00;
    tick();
    chk("t6b_err", 32'(err_o), 32'h1);
    chk("t6b_valid", 32'(grant_valid), 32'h0);
    force_en = 1'b0;
    tick();
    chk("t6b_recover", 32'(grant_onehot), 32'h01);
    chk("t6b_err_sticky", 32'(err_o), 32'h1);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;

    // async reset mid-OFFER with everything pending
    req_i = 8'hFF;
    tick();
    tick();
    req_i = 8'h00;
    chk("t1_pre_pend", 32'(pend_o), 32'hFF);
    chk("t1_pre_valid", 32'(grant_valid), 32'h1);
    chk("t1_pre_drop", 32'(drop_cnt), 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_pend", 32'(pend_o), 32'h00);
    chk("t1_valid", 32'(grant_valid), 32'h0);
    chk("t1_onehot", 32'(grant_onehot), 32'h00);
    chk("t1_idx", 32'(grant_idx), 32'h0);
    chk("t1_drop", 32'(drop_cnt), 32'h00);
    chk("t1_err", 32'(err_o), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_after_valid", 32'(grant_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
